// File: rtl/inst_dec_pkg.sv
// Decode types, opcode constants and the combinational RV32I decoder shared by inst_dec_q.
// INST_DEC_Q_ILLEGAL_CHK_EN enables full illegal-encoding screening inside decode().
package inst_dec_pkg;

  typedef enum logic [3:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_OPIMM,
    OP_SHIFTI, OP_STORE, OP_OP, OP_FENCE, OP_SYSTEM, OP_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    op_class_e   op;
    fmt_e        fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {i[31:12], 12'b0};
      FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t   d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    f3        = instr[14:12];
    f7        = instr[31:25];
    bad       = 1'b0;
    d.op      = OP_ILLEGAL;
    d.fmt     = FMT_NONE;
    d.funct3  = f3;
    d.funct7  = f7;
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.imm     = '0;
    d.rd_we   = 1'b0;
    d.illegal = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin d.op = OP_LUI;    d.fmt = FMT_U; end
      OPC_AUIPC:  begin d.op = OP_AUIPC;  d.fmt = FMT_U; end
      OPC_JAL:    begin d.op = OP_JAL;    d.fmt = FMT_J; end
      OPC_JALR:   begin d.op = OP_JALR;   d.fmt = FMT_I; end
      OPC_BRANCH: begin d.op = OP_BRANCH; d.fmt = FMT_B; end
      OPC_LOAD:   begin d.op = OP_LOAD;   d.fmt = FMT_I; end
      OPC_OPIMM:  begin
        d.op  = (f3 == 3'b001 || f3 == 3'b101) ? OP_SHIFTI : OP_OPIMM;
        d.fmt = FMT_I;
      end
      OPC_STORE:  begin d.op = OP_STORE;  d.fmt = FMT_S; end
      OPC_OP:     begin d.op = OP_OP;     d.fmt = FMT_R; end
      OPC_FENCE:  begin d.op = OP_FENCE;  d.fmt = FMT_I; end
      OPC_SYSTEM: begin d.op = OP_SYSTEM; d.fmt = FMT_I; end
      default:    bad = 1'b1;
    endcase
`ifdef INST_DEC_Q_ILLEGAL_CHK_EN
    case (d.op)
      OP_OP:     bad = !((f7 == 7'b0000000) ||
                         (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      OP_SHIFTI: bad = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                      : !(f7 == 7'b0000000 || f7 == 7'b0100000);
      OP_LOAD:   bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      OP_STORE:  bad = (f3 >= 3'b011);
      OP_BRANCH: bad = (f3 == 3'b010 || f3 == 3'b011);
      OP_JALR:   bad = (f3 != 3'b000);
      default:   ;
    endcase
    if (bad) begin
      d.op      = OP_ILLEGAL;
      d.fmt     = FMT_NONE;
      d.illegal = 1'b1;
    end
`else
    if (bad) d.fmt = FMT_NONE;
`endif
    d.imm   = imm_gen(instr, d.fmt);
    d.rd_we = (d.rd != 5'd0) &&
              !(d.op inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM, OP_ILLEGAL});
    return d;
  endfunction

endpackage

// File: rtl/inst_dec_buf.sv
// DEPTH-entry circular (instr, pc) buffer with flush.
// Latency: 1 cycle push-to-head. Backpressure: in_ready from registered count, no same-cycle pop credit.
module inst_dec_buf #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;

  assign in_ready  = (count < CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= in_instr;
        pc_mem[wr_ptr]    <= in_pc;
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_dec_q.sv
// Elastic decode stage: buffered fetch entries, head decoded combinationally (INST_DEC_Q_ILLEGAL_CHK_EN).
// Latency: 1 cycle when empty. Backpressure: in_ready drops at DEPTH entries; outputs zero when !out_valid.
module inst_dec_q
  import inst_dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_op,
  output logic [2:0]      out_fmt,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  decoded_t        dec;
  logic [XLEN-1:0] imm_ext;

  inst_dec_buf #(.PC_W(PC_W), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (head_instr),
    .out_pc    (head_pc)
  );

  assign dec     = decode(head_instr);
  assign imm_ext = XLEN'($signed(dec.imm));

  // Mask every field so a stale head never leaks while the buffer is empty.
  assign out_pc      = out_valid ? head_pc    : '0;
  assign out_op      = out_valid ? dec.op     : '0;
  assign out_fmt     = out_valid ? dec.fmt    : '0;
  assign out_funct3  = out_valid ? dec.funct3 : '0;
  assign out_funct7  = out_valid ? dec.funct7 : '0;
  assign out_rd      = out_valid ? dec.rd     : '0;
  assign out_rs1     = out_valid ? dec.rs1    : '0;
  assign out_rs2     = out_valid ? dec.rs2    : '0;
  assign out_imm     = out_valid ? imm_ext    : '0;
  assign out_rd_we   = out_valid & dec.rd_we;
  assign out_illegal = out_valid & dec.illegal;

endmodule

// File: tb/tb_inst_dec_q.sv
// Directed checks of inst_dec_q (DEPTH=2, XLEN=32): reset, decode, backpressure, streaming, flush, illegal.
module tb_inst_dec_q;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [3:0]  out_op;
  logic [2:0]  out_fmt;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_rd_we;
  logic        out_illegal;

  int n_chk  = 0;
  int n_fail = 0;
  int pops   = 0;

  inst_dec_q #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_fmt(out_fmt), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_op", out_op, 0);

    // addi x1,x0,5
    push_one(32'h0050_0093, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_op", out_op, 6);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_rd_we", out_rd_we, 1);
    chk("addi_pc", out_pc, 32'h100);
    pop_one();
    chk("addi_drained", out_valid, 0);
    chk("drained_pc_zero", out_pc, 0);

    push_one(32'hFFF0_0093, 32'h104);
    chk("neg1_imm", out_imm, 32'hFFFF_FFFF);
    chk("neg1_op", out_op, 6);
    pop_one();

    // beq x0,x0,-4
    push_one(32'hFE00_0EE3, 32'h108);
    chk("beq_op", out_op, 4);
    chk("beq_fmt", out_fmt, 3);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_rd_we", out_rd_we, 0);
    chk("beq_funct7", out_funct7, 7'h7F);
    pop_one();

    // lui x1,0x12345
    push_one(32'h1234_50B7, 32'h10C);
    chk("lui_op", out_op, 0);
    chk("lui_fmt", out_fmt, 4);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rd_we", out_rd_we, 1);
    pop_one();

    // Backpressure: third push blocked while full, head held.
    in_instr = 32'h0050_0093;
    in_valid = 1'b1;
    in_pc    = 32'h200;
    step();
    in_pc    = 32'h204;
    step();
    chk("bp_full_in_ready", in_ready, 0);
    in_pc = 32'h208;
    step();
    chk("bp_head_held", out_pc, 32'h200);
    chk("bp_still_full", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_drain0", out_pc, 32'h200);
    step();
    chk("bp_drain1", out_pc, 32'h204);
    chk("bp_drain1_valid", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Streaming 20 cycles of simultaneous push+pop.
    in_valid = 1'b1;
    in_pc    = 32'h1000;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'h1000 + 32'(4 * (i + 1));
      chk("stream_valid", out_valid, 1);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_pc", out_pc, 32'h1000 + 32'(4 * i));
      if (out_valid && out_ready) pops++;
      step();
    end
    chk("stream_pops", pops, 20);
    in_valid = 1'b0;
    chk("stream_tail_pc", out_pc, 32'h1050);
    step();
    chk("stream_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush with a push and pop in the same cycle, buffer holding 2.
    push_one(32'h0050_0093, 32'h300);
    push_one(32'h0050_0093, 32'h304);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h308;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    push_one(32'h0050_0093, 32'h400);
    chk("flush_after_pc", out_pc, 32'h400);
    pop_one();
    chk("flush_after_empty", out_valid, 0);

    // OP with funct7 0100000, funct3 100.
    push_one(32'h4000_C0B3, 32'h500);
`ifdef INST_DEC_Q_ILLEGAL_CHK_EN
    chk("ill_flag", out_illegal, 1);
    chk("ill_op", out_op, 12);
    chk("ill_rd_we", out_rd_we, 0);
`else
    chk("ill_flag", out_illegal, 0);
    chk("ill_op", out_op, 9);
    chk("ill_rd_we", out_rd_we, 1);
`endif
    pop_one();

    // Unknown opcode decodes as ILLEGAL in either build.
    push_one(32'h0000_0000, 32'h504);
    chk("unk_op", out_op, 12);
    chk("unk_fmt", out_fmt, 6);
    chk("unk_rd_we", out_rd_we, 0);

    // Async reset mid-stream takes effect without a clock edge.
    push_one(32'h0050_0093, 32'h508);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_pc", out_pc, 0);
    step();
    rst = 1'b0;
    step();
    chk("arst_stays_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
